cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
- REQ-001: Parameter CNT_W, default 8: width of the retired-instruction counter.
- REQ-002: Parameter OP_W, default 2: opcode width.
- REQ-003: clk, input, 1: single clock; all state changes on the rising edge.
- REQ-004: reset, input, 1: asynchronous, active-low reset.
- REQ-005: run, input, 1: level; 1 = execute instructions back-to-back.
- REQ-006: step, input, 1: single-cycle pulse; executes exactly one instruction while halted.
- REQ-007: halt_req, input, 1: level; stop at the next instruction boundary.
- REQ-008: opcode, input, OP_W: instruction-register bits [7:6]. Encoding: 00 ADD, 01 SUB, 10 LOAD, 11 STORE.
- REQ-009: ir_load, output, 1: load the instruction register from instruction memory.
- REQ-010: pc_inc, output, 1: advance the program counter by 1.
- REQ-011: reg_write, mem_read, mem_write, mem_to_reg, outputs, 1 each: datapath controls.
- REQ-012: alu_op, output, 2: ALU operation select.
- REQ-013: halted, output, 1: sequencer is idle.
- REQ-014: busy, output, 1: an instruction is in flight.
- REQ-015: instr_count, output, CNT_W: number of retired instructions.

Function
- REQ-016: States SHALL be IDLE, FETCH, DECODE, EXEC, MEM and WB.
- REQ-017: All control outputs SHALL decode from the state register and the latched opcode only, with no combinational path from run, step or halt_req.
- REQ-018: In IDLE, run=1 or step=1 SHALL go to FETCH next cycle. If both are asserted, run SHALL win.
- REQ-019: FETCH SHALL assert ir_load for 1 cycle, then go to DECODE.
- REQ-020: DECODE SHALL latch opcode into op_q, then:
  - ADD/SUB: go to EXEC.
  - LOAD/STORE: go to MEM.
- REQ-021: EXEC SHALL drive alu_op=op_q, then go to WB.
- REQ-022: MEM SHALL behave by opcode:
  - LOAD: assert mem_read, then go to WB.
  - STORE: assert mem_write and pc_inc; STORE retires here.
- REQ-023: WB SHALL assert reg_write and pc_inc, plus mem_read and mem_to_reg for LOAD and alu_op=op_q for ADD/SUB; the instruction retires here.
- REQ-024: Latency SHALL be 4 cycles FETCH-to-retire for ADD/SUB/LOAD and 3 cycles for STORE.
- REQ-025: At retirement, the next state SHALL be FETCH if run=1, halt_req=0 and the instruction was not started by step; otherwise IDLE.
- REQ-026: halt_req asserted mid-instruction SHALL NOT abort the instruction; it completes, then the sequencer enters IDLE.
- REQ-027: step while not IDLE SHALL be ignored (not queued).
- REQ-028: An internal step_mode flag SHALL set on IDLE->FETCH via step and clear at retirement.
- REQ-029: halted SHALL be 1 iff state==IDLE; busy SHALL be the inverse of halted.
- REQ-030: pc_inc SHALL be asserted exactly once per instruction.
- REQ-031: instr_count SHALL increment by 1 at each retirement and wrap modulo 2^CNT_W (255->0 for the default).
- REQ-032: Outputs not named as asserted in the current state SHALL be 0.

Reset
- REQ-033: reset=0 SHALL asynchronously force state=IDLE, op_q=0, step_mode=0, instr_count=0, halted=1, and all other outputs to 0.
- REQ-034: Reset mid-instruction SHALL abandon the instruction with no pc_inc, reg_write or mem_write.
- REQ-035: After reset release, the first FETCH SHALL occur no earlier than the cycle after run/step is sampled high.

Configuration
- REQ-036: With CPU_SEQ_INSTR_COUNT_EN defined, the retired-instruction counter SHALL be implemented as in REQ-031.
- REQ-037: Without CPU_SEQ_INSTR_COUNT_EN, instr_count SHALL be tied to 0 and no counter flops SHALL exist.

Structure
- REQ-038: A shared package cpu_pkg SHALL hold:
  - the state enum;
  - opcode constants OP_ADD/OP_SUB/OP_LOAD/OP_STORE;
  - ALU op constants.
- REQ-039: One sub-module, cpu_seq_decode, SHALL hold the combinational state/op_q-to-control decode; the next-state logic and registers stay in cpu_sequencer.

Verification
- REQ-040: Reset held, then released with run=0 -> halted=1, all controls 0 and instr_count=0 for 10 cycles.
- REQ-041: run=1 with opcode=00 -> ir_load at cycle 1, reg_write+pc_inc at cycle 4, instr_count=1, then FETCH again at cycle 5.
- REQ-042: run=1 with opcode=11 -> mem_write+pc_inc in the 3rd cycle, reg_write never asserted, next FETCH in the 4th cycle.
- REQ-043: Halted, one step pulse with opcode=10 -> FETCH, DECODE, MEM (mem_read), WB (mem_to_reg+reg_write), then IDLE; instr_count +1. A second step pulse during DECODE is ignored.
- REQ-044: Free run with halt_req raised during EXEC -> WB completes, then IDLE. With reset pulsed low during MEM of a STORE -> immediate IDLE with no mem_write.
- REQ-045: 256 ADD retirements -> instr_count returns to 0. Same test without CPU_SEQ_INSTR_COUNT_EN -> instr_count constantly 0.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// cpu_pkg: shared types and constants for the CPU control sequencer.
//   state_t        : sequencer states IDLE/FETCH/DECODE/EXEC/MEM/WB
//   OP_*           : opcode encodings (instruction-register bits [7:6])
//   ALU_*          : ALU operation select values driven on alu_op
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    // ALU select follows the opcode directly for the arithmetic ops
    localparam logic [1:0] ALU_ADD  = OP_ADD;
    localparam logic [1:0] ALU_SUB  = OP_SUB;
    localparam logic [1:0] ALU_IDLE = 2'b00;

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: control bundle between the sequencer and its datapath.
//   Requests : run, step, halt_req, opcode
//   Controls : ir_load, pc_inc, reg_write, mem_read, mem_write, mem_to_reg, alu_op
//   Status   : halted, busy, instr_count
// Modports: master = sequencer side, slave = datapath / environment side.
interface cpu_sequencer_if #(
    parameter int CNT_W = 8,
    parameter int OP_W  = 2
);
    logic             run;
    logic             step;
    logic             halt_req;
    logic [OP_W-1:0]  opcode;
    logic             ir_load;
    logic             pc_inc;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic [1:0]       alu_op;
    logic             halted;
    logic             busy;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, step, halt_req, opcode,
        output ir_load, pc_inc, reg_write, mem_read, mem_write, mem_to_reg,
               alu_op, halted, busy, instr_count
    );

    modport slave (
        output run, step, halt_req, opcode,
        input  ir_load, pc_inc, reg_write, mem_read, mem_write, mem_to_reg,
               alu_op, halted, busy, instr_count
    );
endinterface

// File: rtl/cpu_sequencer_decode.sv
// cpu_seq_decode: purely combinational control decode from the current state
// and the latched opcode. Inputs: state_i, op_i. Outputs: one control per
// datapath strobe plus halted/busy status. Anything not asserted is 0.
module cpu_seq_decode
    import cpu_pkg::*;
(
    input  state_t     state_i,
    input  logic [1:0] op_i,
    output logic       ir_load_o,
    output logic       pc_inc_o,
    output logic       reg_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       mem_to_reg_o,
    output logic [1:0] alu_op_o,
    output logic       halted_o,
    output logic       busy_o
);
    always_comb begin
        ir_load_o    = 1'b0;
        pc_inc_o     = 1'b0;
        reg_write_o  = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_op_o     = ALU_IDLE;
        halted_o     = (state_i == S_IDLE);
        busy_o       = (state_i != S_IDLE);
        case (state_i)
            S_FETCH: ir_load_o = 1'b1;
            S_EXEC:  alu_op_o  = op_i;
            S_MEM: begin
                if (op_i == OP_STORE) begin
                    mem_write_o = 1'b1;
                    pc_inc_o    = 1'b1;
                end else begin
                    mem_read_o  = 1'b1;
                end
            end
            S_WB: begin
                reg_write_o = 1'b1;
                pc_inc_o    = 1'b1;
                if (op_i == OP_LOAD) begin
                    mem_read_o   = 1'b1;
                    mem_to_reg_o = 1'b1;
                end else begin
                    alu_op_o = op_i;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer (FETCH/DECODE/EXEC|MEM/WB).
// Ports: clk, reset (async active-low), bus (cpu_sequencer_if.master).
// Optional feature: define CPU_SEQ_INSTR_COUNT_EN to build the retired-
// instruction counter; otherwise instr_count is tied to 0.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int OP_W  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    cpu_sequencer_if.master        bus
);
    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            step_mode_q, step_mode_d;
    logic            retire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            step_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            step_mode_q <= step_mode_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        step_mode_d = step_mode_q;
        retire      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b0;
                end else if (bus.step) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b1;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d    = bus.opcode;
                state_d = (bus.opcode[1:0] == OP_LOAD || bus.opcode[1:0] == OP_STORE)
                          ? S_MEM : S_EXEC;
            end
            S_EXEC:   state_d = S_WB;
            S_MEM: begin
                if (op_q[1:0] == OP_STORE) retire  = 1'b1;
                else                       state_d = S_WB;
            end
            S_WB:     retire  = 1'b1;
            default:  state_d = S_IDLE;
        endcase
        // Single retirement point so halt/step/run arbitration is shared by
        // the STORE (MEM) and the WB exits.
        if (retire) begin
            state_d     = (bus.run && !bus.halt_req && !step_mode_q) ? S_FETCH : S_IDLE;
            step_mode_d = 1'b0;
        end
    end

    cpu_seq_decode u_decode (
        .state_i      (state_q),
        .op_i         (op_q[1:0]),
        .ir_load_o    (bus.ir_load),
        .pc_inc_o     (bus.pc_inc),
        .reg_write_o  (bus.reg_write),
        .mem_read_o   (bus.mem_read),
        .mem_write_o  (bus.mem_write),
        .mem_to_reg_o (bus.mem_to_reg),
        .alu_op_o     (bus.alu_op),
        .halted_o     (bus.halted),
        .busy_o       (bus.busy)
    );

`ifdef CPU_SEQ_INSTR_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      cnt_q <= '0;
        else if (retire) cnt_q <= cnt_q + 1'b1;
    end

    assign bus.instr_count = cnt_q;
`else
    logic [CNT_W-1:0] cnt_zero;
    assign cnt_zero        = '0;
    assign bus.instr_count = cnt_zero;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized bench for cpu_sequencer against a
// per-instruction phase model (instruction phase 1..latency, not FSM states).
module tb_cpu_sequencer;
    localparam int CNT_W = 8;
    localparam int OP_W  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_sequencer_if #(.CNT_W(CNT_W), .OP_W(OP_W)) bus ();

    cpu_sequencer #(.CNT_W(CNT_W), .OP_W(OP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // reference model: is an instruction in flight, which cycle of it, etc.
    bit m_active;
    int m_phase;
    int m_op;
    bit m_stepped;
    int m_count;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_active  = 1'b0;
        m_phase   = 0;
        m_op      = 0;
        m_stepped = 1'b0;
        m_count   = 0;
    endfunction

    // One rising edge: cycle 1 fetch, cycle 2 decode (opcode captured),
    // retire on cycle 3 for STORE, cycle 4 otherwise.
    function automatic void model_step();
        int lat;
        if (!reset) begin
            model_reset();
            return;
        end
        if (!m_active) begin
            if (bus.run || bus.step) begin
                m_active  = 1'b1;
                m_phase   = 1;
                m_stepped = !bus.run;
            end
            return;
        end
        if (m_phase == 2) m_op = int'(bus.opcode);
        lat = (m_op == 3) ? 3 : 4;
        if (m_phase >= 3 && m_phase == lat) begin
            m_count++;
            m_active  = bus.run && !bus.halt_req && !m_stepped;
            m_phase   = 1;
            m_stepped = 1'b0;
        end else begin
            m_phase++;
        end
    endfunction

    // {ir_load, pc_inc, reg_write, mem_read, mem_write, mem_to_reg, alu_op, halted, busy}
    function automatic logic [9:0] exp_ctl();
        logic [9:0] v;
        v = '0;
        v[1] = !m_active;
        v[0] = m_active;
        if (m_active) begin
            if (m_phase == 1) v[9] = 1'b1;
            if (m_phase == 3) begin
                if (m_op == 2)      v[6] = 1'b1;
                else if (m_op == 3) begin v[5] = 1'b1; v[8] = 1'b1; end
                else                v[3:2] = m_op[1:0];
            end
            if (m_phase == 4) begin
                v[7] = 1'b1;
                v[8] = 1'b1;
                if (m_op == 2) begin v[6] = 1'b1; v[4] = 1'b1; end
                else           v[3:2] = m_op[1:0];
            end
        end
        return v;
    endfunction

    function automatic logic [9:0] dut_ctl();
        return {bus.ir_load, bus.pc_inc, bus.reg_write, bus.mem_read, bus.mem_write,
                bus.mem_to_reg, bus.alu_op, bus.halted, bus.busy};
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef CPU_SEQ_INSTR_COUNT_EN
        return 32'(m_count % (1 << CNT_W));
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_now(input string tag);
        chk({tag, "_ctl"}, 32'(dut_ctl()), 32'(exp_ctl()));
        chk({tag, "_cnt"}, 32'(bus.instr_count), exp_cnt());
    endtask

    // drive inputs (at negedge), take one clock edge, check at the next negedge
    task automatic cycle(input string tag, input logic r, input logic s,
                         input logic h, input logic [OP_W-1:0] op);
        bus.run      = r;
        bus.step     = s;
        bus.halt_req = h;
        bus.opcode   = op;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_now(tag);
    endtask

    // async reset asserted between edges; outputs must clear immediately
    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_now("rst_async");
        cycle("rst_hold", 1'b1, 1'b0, 1'b0, 2'(OP_W'($urandom_range(0, 3))));
        reset = 1'b1;
    endtask

    initial begin
        bus.run      = 1'b0;
        bus.step     = 1'b0;
        bus.halt_req = 1'b0;
        bus.opcode   = '0;
        reset        = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_now("in_reset");
        end
        reset = 1'b1;

        // idle after release with run low
        repeat (10) cycle("idle", 1'b0, 1'b0, 1'b0, OP_W'($urandom_range(0, 3)));

        // free-running ADDs: enough retirements to wrap the counter
        repeat (260 * 4) cycle("add_run", 1'b1, 1'b0, 1'b0, '0);
        repeat (6) cycle("add_halt", 1'b0, 1'b0, 1'b1, '0);

        // mostly halted: step pulses, occasional run, halt requests
        repeat (600) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            cycle("step_mix", $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0, OP_W'($urandom_range(0, 3)));
        end

        // mostly running with random halts, steps and resets
        repeat (2000) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            cycle("run_mix", $urandom_range(0, 9) < 8, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, OP_W'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
